instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder; inverse of the core's immediate-extraction path. Accepts decoded fields (class, registers, funct3, immediate) over a valid/ready handshake and packs them into 32-bit LOAD, STORE or BRANCH words. Each word is emitted with a word-aligned instruction-memory address from an internal wrapping counter. Used by the test/boot loader to fill instruction memory ahead of the datapath.

---
 rtl/enc_pkg.sv | 33 +++
 rtl/instr_pack.sv | 27 ++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the RV32I LOAD/STORE/BRANCH instruction encoder.
// Opcodes, instruction-class enum, immediate limits and the S1 field bundle.
package enc_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam int IMM_MIN = -2048;
   localparam int IMM_MAX = 2047;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'b00,
      OP_STORE   = 2'b01,
      OP_BRANCH  = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_sel_e;

   typedef struct packed {
      op_sel_e     op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [11:0] imm;
      logic        rej;
   } s1_t;

   function automatic logic imm_out_of_range(input logic [31:0] imm);
      return ($signed(imm) < IMM_MIN) || ($signed(imm) > IMM_MAX);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction class + fields -> 32-bit RV32I word.
// No state; the illegal class packs to zero.
module instr_pack
   import enc_pkg::*;
(
   input  op_sel_e     i_op,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic [11:0] i_imm,
   output logic [31:0] o_instr
);

   always_comb begin
      o_instr = '0;
      case (i_op)
         OP_LOAD:   o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
         OP_STORE:  o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
         // B-type scrambles the halfword offset: sign, [9:4] high; [3:0], [10] low.
         OP_BRANCH: o_instr = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3,
                               i_imm[3:0], i_imm[10], OPC_BRANCH};
         default:   o_instr = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I encoder with wrapping word address; 2-cycle latency, 1 word/cycle,
// in_ready stalls on out_ready. ENC_RANGE_CHECK_EN: reject immediates outside signed 12 bits.
module instr_encoder
   import enc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 64
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op_sel,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        wrap,
   output logic [7:0]  err_cnt
);

`ifdef ENC_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

   logic        r_s1_vld;
   s1_t         r_s1;
   logic        r_s2_vld;
   logic [31:0] r_s2_instr;
   logic [31:0] r_addr;
   logic [7:0]  r_err;

   s1_t         w_s1_nxt;
   logic        w_s2_adv;
   logic        w_s1_fwd;
   logic        w_out_hs;
   logic [31:0] w_pack;

   assign w_s2_adv = !r_s2_vld || out_ready;
   assign w_out_hs = r_s2_vld && out_ready;
   assign w_s1_fwd = r_s1_vld && !r_s1.rej;
   // Gated by rst_n so the encoder refuses input while reset is held.
   assign in_ready = rst_n && (!r_s1_vld || w_s2_adv);

   always_comb begin
      w_s1_nxt        = '0;
      w_s1_nxt.op     = op_sel_e'(op_sel);
      w_s1_nxt.rd     = rd;
      w_s1_nxt.rs1    = rs1;
      w_s1_nxt.rs2    = rs2;
      w_s1_nxt.funct3 = funct3;
      w_s1_nxt.imm    = imm[11:0];
      w_s1_nxt.rej    = (op_sel_e'(op_sel) == OP_ILLEGAL) ||
                        (RANGE_CHECK && imm_out_of_range(imm));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s1     <= '0;
      end else if (in_ready) begin
         r_s1_vld <= in_valid;
         if (in_valid) r_s1 <= w_s1_nxt;
      end
   end

   instr_pack u_pack (
      .i_op     (r_s1.op),
      .i_rd     (r_s1.rd),
      .i_rs1    (r_s1.rs1),
      .i_rs2    (r_s1.rs2),
      .i_funct3 (r_s1.funct3),
      .i_imm    (r_s1.imm),
      .o_instr  (w_pack)
   );

   // Rejected fields vanish here: S2 stays empty and the address does not move.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld   <= 1'b0;
         r_s2_instr <= '0;
      end else if (w_s2_adv) begin
         r_s2_vld <= w_s1_fwd;
         if (w_s1_fwd) r_s2_instr <= w_pack;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= '0;
      end else if (w_s2_adv && r_s1_vld && r_s1.rej && (r_err != 8'hFF)) begin
         r_err <= r_err + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= BASE_ADDR;
      end else if (w_out_hs) begin
         r_addr <= (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + 32'd4;
      end
   end

   assign out_valid = r_s2_vld;
   assign out_instr = r_s2_instr;
   assign out_addr  = r_addr;
   assign wrap      = w_out_hs && (r_addr == LAST_ADDR);
   assign err_cnt   = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (BASE_ADDR=0x100, DEPTH=4) with a queue model
// checked on every output-valid cycle; honours ENC_RANGE_CHECK_EN.
module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam logic [31:0] BASE = 32'h100;
   localparam int          DEP  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op_sel = 2'b00;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr, out_addr;
   logic        wrap;
   logic [7:0]  err_cnt;

   instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .wrap(wrap), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        wrap;
      int          cyc;
   } ent_t;

   ent_t mq[$];
   ent_t log_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   k = 0;
   int   m_err = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_instr = '0, prev_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_to(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out", nm);
   endtask

   function automatic logic [31:0] ref_encode(input logic [1:0] op, input logic [4:0] d,
         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f, input logic [31:0] im);
      logic [11:0] i;
      i = im[11:0];
      case (op)
         2'b00:   return {i, s1, f, d, 7'b0000011};
         2'b01:   return {i[11:5], s2, s1, f, i[4:0], 7'b0100011};
         2'b10:   return {i[11], i[9:4], s2, s1, f, i[3:0], i[10], 7'b1100011};
         default: return 32'h0;
      endcase
   endfunction

   // Model: one entry per accepted legal word; address is its ordinal modulo DEPTH.
   task automatic model_accept();
      ent_t e;
      logic oor;
      oor = ($signed(imm) < -2048) || ($signed(imm) > 2047);
      if (op_sel == 2'b11 || (RC && oor)) begin
         if (m_err < 255) m_err++;
      end else begin
         e.instr = ref_encode(op_sel, rd, rs1, rs2, funct3, imm);
         e.addr  = BASE + 32'(4 * k);
         e.wrap  = (k == DEP - 1);
         e.cyc   = 0;
         mq.push_back(e);
         k = (k + 1) % DEP;
      end
   endtask

   always @(negedge clk) begin
      logic hs, exp_wrap;
      ent_t e;
      if (!rst_n) begin
         mq.delete();
         k = 0;
         m_err = 0;
         prev_stall = 1'b0;
      end else begin
         hs = out_valid && out_ready;
         exp_wrap = 1'b0;
         if (out_valid) begin
            if (mq.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'h0);
            end else begin
               chk("mon_instr", out_instr, mq[0].instr);
               chk("mon_addr", out_addr, mq[0].addr);
               exp_wrap = hs && mq[0].wrap;
            end
         end
         chk("mon_wrap", 32'(wrap), 32'(exp_wrap));
         if (prev_stall) begin
            chk("stall_instr_stable", out_instr, prev_instr);
            chk("stall_addr_stable", out_addr, prev_addr);
         end
         if (hs && mq.size() > 0) begin
            e.instr = out_instr;
            e.addr  = out_addr;
            e.wrap  = wrap;
            e.cyc   = cyc;
            log_q.push_back(e);
            void'(mq.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_instr = out_instr;
         prev_addr  = out_addr;
         if (in_valid && in_ready) model_accept();
      end
   end

   task automatic set_in(input logic [1:0] op, input logic [4:0] d, input logic [4:0] s1,
         input logic [4:0] s2, input logic [2:0] f, input logic [31:0] im);
      op_sel = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f; imm = im;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [4:0] d, input logic [4:0] s1,
         input logic [4:0] s2, input logic [2:0] f, input logic [31:0] im);
      bit ok;
      ok = 1'b0;
      set_in(op, d, s1, s2, f, im);
      in_valid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) fail_to("send");
   endtask

   task automatic wait_word(input string nm, input logic [31:0] ei, input logic [31:0] ea,
         input logic ew, output int c);
      ent_t e;
      int n;
      n = 0;
      c = -1;
      while (log_q.size() == 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (log_q.size() == 0) begin
         fail_to(nm);
      end else begin
         e = log_q.pop_front();
         c = e.cyc;
         chk({nm, "_instr"}, e.instr, ei);
         chk({nm, "_addr"}, e.addr, ea);
         chk({nm, "_wrap"}, 32'(e.wrap), 32'(ew));
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      log_q.delete();
      @(posedge clk);
      #1;
   endtask

   logic [1:0]  t_op [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
   logic [4:0]  t_rd [12] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd31, 5'd0, 5'd0, 5'd0, 5'd10, 5'd0, 5'd0, 5'd3};
   logic [4:0]  t_s1 [12] = '{5'd2, 5'd3, 5'd5, 5'd1, 5'd31, 5'd0, 5'd7, 5'd9, 5'd11, 5'd12, 5'd1, 5'd4};
   logic [4:0]  t_s2 [12] = '{5'd0, 5'd4, 5'd6, 5'd1, 5'd0, 5'd31, 5'd8, 5'd10, 5'd0, 5'd13, 5'd2, 5'd0};
   logic [2:0]  t_f3 [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd7, 3'd0, 3'd4, 3'd5, 3'd4, 3'd2, 3'd6, 3'd1};
   logic [31:0] t_im [12] = '{-32'sd2048, 32'sd2047, -32'sd1, 32'sd0, 32'sd2047, -32'sd2048,
                              -32'sd2048, 32'sd2047, 32'sd100, -32'sd100, 32'sd300, 32'sd4096};
   logic [7:0]  pat = 8'b1011_0010;

   initial begin
      int c1, c2, c3, n_acc, idx, n;
      bit acc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_addr", out_addr, BASE);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_err_cnt", 32'(err_cnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;

      // LOAD latency and encoding
      send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);
      chk("lat_c1_valid", 32'(out_valid), 32'h0);
      @(posedge clk);
      #1;
      chk("lat_c2_valid", 32'(out_valid), 32'h1);
      chk("lat_c2_instr", out_instr, 32'h00812283);
      chk("lat_c2_addr", out_addr, BASE);
      wait_word("load", 32'h00812283, BASE, 1'b0, c1);

      // STORE then BRANCH
      do_reset();
      send(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, -32'sd4);
      send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8);
      wait_word("store", 32'hFE612E23, BASE, 1'b0, c1);
      wait_word("branch", 32'h00208863, BASE + 32'd4, 1'b0, c2);

      // Range check / illegal class
      do_reset();
      send(2'b00, 5'd1, 5'd3, 5'd0, 3'b000, 32'd2048);
      send(2'b11, 5'd1, 5'd1, 5'd1, 3'b000, 32'd0);
      send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);
      if (RC) begin
         wait_word("rng_legal", 32'h00812283, BASE, 1'b0, c1);
         chk("rng_err_cnt", 32'(err_cnt), 32'd2);
      end else begin
         wait_word("rng_trunc", 32'h80018083, BASE, 1'b0, c1);
         wait_word("rng_legal", 32'h00812283, BASE + 32'd4, 1'b0, c2);
         chk("rng_err_cnt", 32'(err_cnt), 32'd1);
      end

      // Back-pressure: 4 stalled cycles offering 3 words
      do_reset();
      out_ready = 1'b0;
      n_acc = 0;
      idx = 0;
      set_in(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 2) chk("bp_in_ready_low", 32'(in_ready), 32'h0);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            n_acc++;
            idx++;
            if (idx == 1) set_in(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, -32'sd4);
            if (idx == 2) set_in(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8);
         end
      end
      chk("bp_accepts", 32'(n_acc), 32'd2);
      out_ready = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) fail_to("bp_third_accept");
      wait_word("bp_w0", 32'h00812283, BASE, 1'b0, c1);
      wait_word("bp_w1", 32'hFE612E23, BASE + 32'd4, 1'b0, c2);
      wait_word("bp_w2", 32'h00208863, BASE + 32'd8, 1'b0, c3);
      chk("bp_gap01", 32'(c2 - c1), 32'd1);
      chk("bp_gap12", 32'(c3 - c2), 32'd1);

      // Address wrap at DEPTH=4
      do_reset();
      for (int i = 0; i < 5; i++) send(2'b00, 5'(i), 5'd1, 5'd0, 3'b010, 32'(4 * i));
      wait_word("wr0", ref_encode(2'b00, 5'd0, 5'd1, 5'd0, 3'b010, 32'd0),  32'h100, 1'b0, c1);
      wait_word("wr1", ref_encode(2'b00, 5'd1, 5'd1, 5'd0, 3'b010, 32'd4),  32'h104, 1'b0, c1);
      wait_word("wr2", ref_encode(2'b00, 5'd2, 5'd1, 5'd0, 3'b010, 32'd8),  32'h108, 1'b0, c1);
      wait_word("wr3", ref_encode(2'b00, 5'd3, 5'd1, 5'd0, 3'b010, 32'd12), 32'h10C, 1'b1, c1);
      wait_word("wr4", ref_encode(2'b00, 5'd4, 5'd1, 5'd0, 3'b010, 32'd16), 32'h100, 1'b0, c1);

      // Mixed stream under a toggling out_ready pattern
      do_reset();
      fork
         begin
            for (int i = 0; i < 12; i++) send(t_op[i], t_rd[i], t_s1[i], t_s2[i], t_f3[i], t_im[i]);
         end
         begin
            for (int c = 0; c < 40; c++) begin
               @(posedge clk);
               #1;
               out_ready = pat[c % 8];
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while ((out_valid || mq.size() > 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mix_model_drained", 32'(mq.size()), 32'd0);
      chk("mix_err_model", 32'(err_cnt), 32'(m_err));
      chk("mix_err_literal", 32'(err_cnt), RC ? 32'd2 : 32'd1);
      log_q.delete();

      // Asynchronous reset with both stages full
      do_reset();
      out_ready = 1'b0;
      send(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
      send(2'b00, 5'd7, 5'd8, 5'd0, 3'b000, 32'd1);
      send(2'b01, 5'd0, 5'd8, 5'd9, 3'b000, 32'd2);
      @(posedge clk);
      #1;
      chk("full_in_ready", 32'(in_ready), 32'h0);
      chk("full_out_valid", 32'(out_valid), 32'h1);
      chk("full_err_cnt", 32'(err_cnt), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'h0);
      chk("arst_in_ready", 32'(in_ready), 32'h0);
      chk("arst_out_addr", out_addr, BASE);
      chk("arst_out_instr", out_instr, 32'h0);
      chk("arst_err_cnt", 32'(err_cnt), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      log_q.delete();
      @(negedge clk);
      chk("arst_rel_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);
      wait_word("arst_next", 32'h00812283, BASE, 1'b0, c1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
